painel7seg_pisca: RTL and testbench
===================================

// Module: painel7seg_pisca
// PURPOSE
//   Registered, multi-digit successor of the 5-bit state decoder for the DE0-CV 7-segment displays.
//   It holds N_DIG 5-bit codes, one per digit, loaded as a group, and decodes each with the standard table.
//   Per-digit blink and blank controls are added, with blink timing driven by an internal divider.
//   It sits between the FSM/datapath debug outputs and the HEXn pins.
// PARAMETERS
//   N_DIG        2           number of digits driven (>=1)
//   MEIO_PERIODO 25000000    blink half-period in clock cycles (>=1); 0.5 s at 50 MHz
//   ATIVO_BAIXO  1           1: segment on = 0 (DE0-CV); 0: all output bits inverted
// PORTS
//   clock      in   1         system clock, rising edge
//   reset      in   1         synchronous, active-high
//   carrega    in   1         load strobe; samples valor this edge
//   valor      in   5*N_DIG   digit i code = valor[5*i+4:5*i]
//   pisca      in   N_DIG     per-digit blink enable (level, not registered)
//   apaga      in   N_DIG     per-digit forced blank (level, not registered)
//   display    out  7*N_DIG   digit i = display[7*i+6:7*i]; bit 6 = segment g
//   fase_pisca out  1         current blink phase; 0 = visible, 1 = hidden
// BEHAVIOUR
//   - Decode table (ATIVO_BAIXO=1, hex), codes 00..1F in order:
//     40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E
//     7E 7D 7B 77 6F 5F 3F 7C 73 67 4F 1F 71 63 47 0F
//   - Blank pattern = 7F. With ATIVO_BAIXO=0, decoded and blank patterns are bitwise inverted.
//   - Registers: reg_valor (5*N_DIG), cnt (max(1,clog2(MEIO_PERIODO)) bits), fase, and display (registered output).
//   - reset=1 has priority over all other inputs:
//     - reg_valor=0, cnt=0, fase=0.
//     - Every display digit = blank.
//     - All take effect at the same edge; this also applies mid-blink.
//   - carrega=1 at edge t: reg_valor<=valor, cnt<=0, fase<=0. Blink restarts so a new value is shown immediately.
//   - Otherwise, each edge: if cnt==MEIO_PERIODO-1 then cnt<=0 and fase<=~fase, else cnt<=cnt+1.
//     - With MEIO_PERIODO=1, fase toggles every edge.
//   - Display register, each edge, per digit i, first match wins:
//     - apaga[i]=1 -> blank
//     - pisca[i]=1 and fase=1 -> blank
//     - otherwise -> decode(reg_valor digit i)
//   - Latency:
//     - Load at edge t appears on display at edge t+1.
//     - apaga/pisca changes appear one edge after they are sampled.
//     - A fase toggle at edge t affects display at edge t+1.
//   - carrega held high: reloads every edge and keeps fase=0 and cnt=0, so blinking digits stay visible.
//   - Digits are fully independent. There is no scan multiplexing; all digits update in the same cycle.
//   - fase_pisca = fase register, which resets to 0.
// TESTING  (N_DIG=2, MEIO_PERIODO=4, ATIVO_BAIXO=1)
//   1. reset 2 cycles
//      -> display=14'h3FFF, fase_pisca=0.
//   2. carrega pulse, valor=10'b01010_00011 (A,3), pisca=0, apaga=0
//      -> one edge later display={7'h08,7'h30}; holds after valor changes with carrega=0.
//   3. Sweep all 32 codes on both digits, one load each
//      -> every digit matches the table; code 1F -> 7'h0F.
//   4. pisca=2'b01 after load
//      -> digit0 alternates 30/7F every 4 cycles, digit1 stays 08; fase_pisca toggles every 4 edges.
//   5. carrega mid-hidden phase (fase=1)
//      -> next edge fase=0, digit0 visible with the new code; next toggle 4 edges later.
//   6. apaga=2'b10 with pisca=2'b10, then reset asserted mid-blink
//      -> digit1 is 7F throughout; after reset all 7F, cnt=0, fase=0.

Source files
------------

// File: rtl/painel7seg_pisca.sv
// painel7seg_pisca
//   Registered multi-digit 7-segment driver for the DE0-CV HEXn displays.
//   Holds N_DIG 5-bit state codes, loaded together, and decodes each one
//   with the standard state table. Every digit can be blanked or made to
//   blink. The blink phase comes from an internal half-period divider.
//
// Parameters
//   N_DIG        number of digits driven (>= 1)
//   MEIO_PERIODO blink half-period in clock cycles (>= 1)
//   ATIVO_BAIXO  1: segment on = 0 (DE0-CV); 0: every output bit inverted
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-high; blanks all digits
//   carrega    in   load strobe; valor is sampled at this edge
//   valor      in   digit i code = valor[5*i+4:5*i]
//   pisca      in   per-digit blink enable (level)
//   apaga      in   per-digit forced blank (level)
//   display    out  digit i = display[7*i+6:7*i]; bit 6 = segment g
//   fase_pisca out  blink phase; 0 = visible, 1 = hidden
module painel7seg_pisca #(
  parameter int N_DIG        = 2,
  parameter int MEIO_PERIODO = 25000000,
  parameter bit ATIVO_BAIXO  = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 carrega,
  input  logic [5*N_DIG-1:0]   valor,
  input  logic [N_DIG-1:0]     pisca,
  input  logic [N_DIG-1:0]     apaga,
  output logic [7*N_DIG-1:0]   display,
  output logic                 fase_pisca
);

  // Counter needs at least one bit so MEIO_PERIODO=1 still builds.
  localparam int CNT_W = (MEIO_PERIODO > 1) ? $clog2(MEIO_PERIODO) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEIO_PERIODO - 1);
  localparam logic [6:0] SEG_BLANK = ATIVO_BAIXO ? 7'h7F : 7'h00;

  logic [5*N_DIG-1:0] reg_valor;
  logic [CNT_W-1:0]   cnt;
  logic               fase;
  logic [7*N_DIG-1:0] disp_next;

  // Active-low segment table, polarity applied on return.
  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] seg;
    case (code)
      5'h00: seg = 7'h40;
      5'h01: seg = 7'h79;
      5'h02: seg = 7'h24;
      5'h03: seg = 7'h30;
      5'h04: seg = 7'h19;
      5'h05: seg = 7'h12;
      5'h06: seg = 7'h02;
      5'h07: seg = 7'h78;
      5'h08: seg = 7'h00;
      5'h09: seg = 7'h10;
      5'h0A: seg = 7'h08;
      5'h0B: seg = 7'h03;
      5'h0C: seg = 7'h46;
      5'h0D: seg = 7'h21;
      5'h0E: seg = 7'h06;
      5'h0F: seg = 7'h0E;
      5'h10: seg = 7'h7E;
      5'h11: seg = 7'h7D;
      5'h12: seg = 7'h7B;
      5'h13: seg = 7'h77;
      5'h14: seg = 7'h6F;
      5'h15: seg = 7'h5F;
      5'h16: seg = 7'h3F;
      5'h17: seg = 7'h7C;
      5'h18: seg = 7'h73;
      5'h19: seg = 7'h67;
      5'h1A: seg = 7'h4F;
      5'h1B: seg = 7'h1F;
      5'h1C: seg = 7'h71;
      5'h1D: seg = 7'h63;
      5'h1E: seg = 7'h47;
      5'h1F: seg = 7'h0F;
      default: seg = 7'h7F;
    endcase
    return ATIVO_BAIXO ? seg : ~seg;
  endfunction

  // Next display image from the current (pre-edge) value and phase, so a
  // load or a phase toggle shows up one edge later.
  always_comb begin
    disp_next = '0;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      if (apaga[i] || (pisca[i] && fase))
        disp_next[7*i +: 7] = SEG_BLANK;
      else
        disp_next[7*i +: 7] = decode(reg_valor[5*i +: 5]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      reg_valor <= '0;
      cnt       <= '0;
      fase      <= 1'b0;
      display   <= {N_DIG{SEG_BLANK}};
    end else begin
      display <= disp_next;
      if (carrega) begin
        // Restart the blink so the freshly loaded value is visible at once.
        reg_valor <= valor;
        cnt       <= '0;
        fase      <= 1'b0;
      end else if (cnt == CNT_MAX) begin
        cnt  <= '0;
        fase <= ~fase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign fase_pisca = fase;

endmodule

// File: tb/tb_painel7seg_pisca.sv
module tb_painel7seg_pisca;

  localparam int N  = 2;
  localparam int MP = 4;

  logic         clock = 1'b0;
  logic         reset, carrega;
  logic [9:0]   valor;
  logic [1:0]   pisca, apaga;
  logic [13:0]  display;
  logic         fase_pisca;

  always #5 clock = ~clock;

  painel7seg_pisca #(
    .N_DIG(N),
    .MEIO_PERIODO(MP),
    .ATIVO_BAIXO(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .carrega(carrega),
    .valor(valor),
    .pisca(pisca),
    .apaga(apaga),
    .display(display),
    .fase_pisca(fase_pisca)
  );

  // Reference decode table, codes 00..1F
  logic [6:0] tabela [32];
  initial tabela = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
                     7'h7E, 7'h7D, 7'h7B, 7'h77, 7'h6F, 7'h5F, 7'h3F, 7'h7C,
                     7'h73, 7'h67, 7'h4F, 7'h1F, 7'h71, 7'h63, 7'h47, 7'h0F};

  typedef struct packed {
    logic [13:0] disp;
    logic        fase;
  } exp_t;

  exp_t fila[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: shown codes and edges elapsed since last load/reset.
  int mv[2];
  int k;

  function automatic int fase_de(input int edges);
    return (edges / MP) % 2;
  endfunction

  task automatic step(input logic r, input logic ld, input logic [9:0] v,
                      input logic [1:0] p, input logic [1:0] a);
    exp_t e;
    int   f;
    @(negedge clock);
    reset   = r;
    carrega = ld;
    valor   = v;
    pisca   = p;
    apaga   = a;
    f = fase_de(k);
    for (int i = 0; i < N; i++) begin
      if (r || a[i] || (p[i] && f == 1))
        e.disp[7*i +: 7] = 7'h7F;
      else
        e.disp[7*i +: 7] = tabela[mv[i]];
    end
    if (r) begin
      mv[0] = 0; mv[1] = 0; k = 0;
    end else if (ld) begin
      mv[0] = int'(v[4:0]); mv[1] = int'(v[9:5]); k = 0;
    end else begin
      k++;
    end
    e.fase = (fase_de(k) == 1);
    fila.push_back(e);
  endtask

  // Monitor: one registered output image per edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (fila.size() > 0) begin
        e = fila.pop_front();
        checks++;
        if (display !== e.disp || fase_pisca !== e.fase) begin
          errors++;
          $display("FAIL out t=%0t: display=%h fase=%b expected display=%h fase=%b",
                   $time, display, fase_pisca, e.disp, e.fase);
        end
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b1; carrega = 1'b0; valor = '0; pisca = '0; apaga = '0;
    mv[0] = 0; mv[1] = 0; k = 0;

    // reset, two cycles
    step(1'b1, 1'b0, '0, 2'b00, 2'b00);
    step(1'b1, 1'b0, '0, 2'b00, 2'b00);

    // load (A,3) then valor wanders with carrega low
    step(1'b0, 1'b1, {5'h0A, 5'h03}, 2'b00, 2'b00);
    repeat (6) step(1'b0, 1'b0, 10'($urandom), 2'b00, 2'b00);

    // sweep all codes on both digits
    for (int c = 0; c < 32; c++) begin
      step(1'b0, 1'b1, {5'(31 - c), 5'(c)}, 2'b00, 2'b00);
      step(1'b0, 1'b0, 10'($urandom), 2'b00, 2'b00);
    end

    // digit0 blinks, digit1 steady
    step(1'b0, 1'b1, {5'h0A, 5'h03}, 2'b00, 2'b00);
    repeat (20) step(1'b0, 1'b0, '0, 2'b01, 2'b00);

    // load during hidden phase
    guard = 0;
    while (fase_de(k) != 1 && guard < 10) begin
      step(1'b0, 1'b0, '0, 2'b01, 2'b00);
      guard++;
    end
    step(1'b0, 1'b1, {5'h05, 5'h0C}, 2'b01, 2'b00);
    repeat (12) step(1'b0, 1'b0, '0, 2'b01, 2'b00);

    // digit1 forced blank while blinking, reset mid-blink
    step(1'b0, 1'b1, {5'h1F, 5'h10}, 2'b10, 2'b10);
    repeat (6) step(1'b0, 1'b0, '0, 2'b10, 2'b10);
    step(1'b1, 1'b0, '0, 2'b10, 2'b10);
    repeat (6) step(1'b0, 1'b0, '0, 2'b10, 2'b10);

    // carrega held high keeps blinking digits visible
    repeat (10) step(1'b0, 1'b1, 10'($urandom), 2'b11, 2'b00);

    // random traffic
    repeat (400) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
           10'($urandom), 2'($urandom),
           ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
    end

    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (fila.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs pending, expected 0", fila.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
